// File: rtl/field_scan_sel.sv
// Field selector over an N-field packed word: DIRECT pick, SCAN stream of every field,
// and wrap-around SEARCH for the first field equal to KEY. All outputs are registered.
module field_scan_sel #(
    parameter int W = 2,
    parameter int N = 4,
    localparam int SW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [N*W-1:0] X,
    input  logic [SW-1:0] SEL,
    input  logic [1:0]    MODE,
    input  logic [W-1:0]  KEY,
    input  logic          START,
    output logic [W-1:0]  Y,
    output logic [SW-1:0] IDX,
    output logic          E,
    output logic          VALID,
    output logic          LAST,
    output logic          BUSY,
    output logic          ERR,
    output logic [1:0]    STATE_DBG
);

    // Handshake: a request is accepted on any edge where START=1 and BUSY=0 (state IDLE);
    // START is ignored while BUSY=1. Each output beat is a one-cycle VALID strobe, LAST marks
    // the final beat, and Y/IDX/E are meaningful only while VALID=1 (they hold otherwise).

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_SRCH = 2'd2
    } state_t;

    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);
    localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);

    state_t         state_q, state_d;
    logic [SW-1:0]  ptr_q, ptr_d;
    logic [N*W-1:0] snap_x_q, snap_x_d;
    logic [SW-1:0]  snap_sel_q, snap_sel_d;
    logic [W-1:0]   snap_key_q, snap_key_d;
    logic [W-1:0]   y_q, y_d;
    logic [SW-1:0]  idx_q, idx_d;
    logic           e_q, e_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    logic           sel_bad, is_scan, is_srch;
    logic [W-1:0]   x_fld, s_fld;
    logic           s_hit, s_exhaust;

    // Out-of-range indices read as zero, so N need not be a power of two.
    function automatic logic [W-1:0] fld(input logic [N*W-1:0] v, input logic [SW-1:0] i);
        fld = '0;
        for (int k = 0; k < N; k++) begin
            if (i == SW'(k)) fld = v[k*W +: W];
        end
    endfunction

    function automatic logic [SW-1:0] nxt(input logic [SW-1:0] p);
        if (p == LAST_IDX) nxt = '0;
        else               nxt = p + SW'(1);
    endfunction

    assign sel_bad   = ({1'b0, SEL} >= N_EXT);
    assign is_scan   = (MODE == 2'b01);
    assign is_srch   = (MODE == 2'b10);
    assign x_fld     = fld(X, SEL);
    assign s_fld     = fld(snap_x_q, ptr_q);
    assign s_hit     = (s_fld == snap_key_q);
    // The search has covered all N fields once the pointer would come back to the start.
    assign s_exhaust = (nxt(ptr_q) == snap_sel_q);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            snap_x_q   <= '0;
            snap_sel_q <= '0;
            snap_key_q <= '0;
            y_q        <= '0;
            idx_q      <= '0;
            e_q        <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            snap_x_q   <= snap_x_d;
            snap_sel_q <= snap_sel_d;
            snap_key_q <= snap_key_d;
            y_q        <= y_d;
            idx_q      <= idx_d;
            e_q        <= e_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (START && !sel_bad) begin
                    if (is_scan)                      state_d = S_SCAN;
                    else if (is_srch && x_fld != KEY) state_d = S_SRCH;
                end
            end
            S_SCAN:  if (ptr_q == LAST_IDX)    state_d = S_IDLE;
            S_SRCH:  if (s_hit || s_exhaust)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        snap_x_d   = snap_x_q;
        snap_sel_d = snap_sel_q;
        snap_key_d = snap_key_q;
        y_d        = y_q;
        idx_d      = idx_q;
        e_d        = e_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    snap_x_d   = X;
                    snap_sel_d = SEL;
                    snap_key_d = KEY;
                    if (sel_bad) begin
                        y_d     = '0;
                        idx_d   = SEL;
                        e_d     = 1'b0;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (is_scan) begin
                        // Beat 0 comes straight from the live input on the accept edge.
                        y_d     = fld(X, '0);
                        idx_d   = '0;
                        e_d     = (fld(X, '0) == KEY);
                        valid_d = 1'b1;
                        ptr_d   = nxt('0);
                    end else if (is_srch && x_fld != KEY) begin
                        ptr_d   = nxt(SEL);
                    end else begin
                        y_d     = x_fld;
                        idx_d   = SEL;
                        e_d     = (x_fld == KEY);
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                y_d     = s_fld;
                idx_d   = ptr_q;
                e_d     = s_hit;
                valid_d = 1'b1;
                last_d  = (ptr_q == LAST_IDX);
                ptr_d   = nxt(ptr_q);
            end
            S_SRCH: begin
                if (s_hit) begin
                    y_d     = s_fld;
                    idx_d   = ptr_q;
                    e_d     = 1'b1;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                end else if (s_exhaust) begin
                    y_d     = '0;
                    idx_d   = snap_sel_q;
                    e_d     = 1'b0;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                end else begin
                    ptr_d   = nxt(ptr_q);
                end
            end
            default: ;
        endcase
    end

    assign Y         = y_q;
    assign IDX       = idx_q;
    assign E         = e_q;
    assign VALID     = valid_q;
    assign LAST      = last_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;
    assign STATE_DBG = state_q;

endmodule
